serial_mag_comparator: RTL

- Sequential multi-digit magnitude comparator that sits downstream of the 2-bit comparator cell (A1/A0 vs B1/B0 giving F1/F2/F3).
- Consumes operand pairs as 2-bit digits, one pair per cycle, MSB digit first.
- Resolves greater/equal/less for words up to MAX_DIGITS digits long, then reports the result with a one-cycle done pulse.
- Extends the single-cell compare to arbitrary-length operands without widening the combinational path.

---
 rtl/serial_mag_comparator_if.sv | 28 ++
 rtl/serial_mag_comparator.sv | 112 +++++++++++
 2 files changed

// File: rtl/serial_mag_comparator_if.sv
// Digit-stream bus of the serial magnitude comparator: operand digits in,
// handshake/result flags out.
interface serial_mag_comparator_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic             din_valid;
  logic             din_last;
  logic [1:0]       a_digit;
  logic [1:0]       b_digit;
  logic             ready;
  logic             done;
  logic             gt;
  logic             eq;
  logic             lt;
  logic             err;
  logic [CNT_W-1:0] digit_cnt;

  modport master (
    output start, din_valid, din_last, a_digit, b_digit,
    input  ready, done, gt, eq, lt, err, digit_cnt
  );

  modport slave (
    input  start, din_valid, din_last, a_digit, b_digit,
    output ready, done, gt, eq, lt, err, digit_cnt
  );
endinterface

// File: rtl/serial_mag_comparator.sv
// Serial MSB-first magnitude comparator over 2-bit digits; the first unequal
// digit decides the word, the result is reported with a one-cycle done pulse.
module serial_mag_comparator #(
  parameter int MAX_DIGITS = 8,
  parameter int CNT_W      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  serial_mag_comparator_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             decided_q, decided_d;
  logic             dgt_q, dgt_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      dgt_q     <= 1'b0;
      gt_q      <= 1'b0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      dgt_q     <= dgt_d;
      gt_q      <= gt_d;
      eq_q      <= eq_d;
      lt_q      <= lt_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    dgt_d     = dgt_q;
    gt_d      = gt_q;
    eq_d      = eq_q;
    lt_d      = lt_q;
    err_d     = err_q;

    // start wins in every state and drops any digit presented with it
    if (bus.start) begin
      state_d   = COMPARE;
      cnt_d     = '0;
      decided_d = 1'b0;
      dgt_d     = 1'b0;
      gt_d      = 1'b0;
      eq_d      = 1'b0;
      lt_d      = 1'b0;
      err_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        COMPARE: begin
          if (bus.din_valid) begin
            cnt_d = (cnt_q == CNT_W'(MAX_DIGITS)) ? cnt_q : cnt_q + 1'b1;
            if (!decided_q && (bus.a_digit != bus.b_digit)) begin
              decided_d = 1'b1;
              dgt_d     = (bus.a_digit > bus.b_digit);
            end
            if (bus.din_last) begin
              state_d = DONE;
              gt_d    = decided_d && dgt_d;
              lt_d    = decided_d && !dgt_d;
              eq_d    = !decided_d;
            end else if (cnt_q == CNT_W'(MAX_DIGITS - 1)) begin
              state_d = DONE;
              err_d   = 1'b1;
              gt_d    = 1'b0;
              eq_d    = 1'b0;
              lt_d    = 1'b0;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    ready_d = (state_d == COMPARE);
    done_d  = (state_d == DONE);
  end

  assign bus.ready     = ready_q;
  assign bus.done      = done_q;
  assign bus.gt        = gt_q;
  assign bus.eq        = eq_q;
  assign bus.lt        = lt_q;
  assign bus.err       = err_q;
  assign bus.digit_cnt = cnt_q;

endmodule
